// File: rtl/slip_timer_seq_if.sv
// Control and status bundle between the CPU/prescaler side and the slip timer
// sequencer. The master drives the control pulses; the slave reports counter state.
interface slip_timer_seq_if #(parameter int WIDTH = 9);
  logic             tick;
  logic             load_wr;
  logic [WIDTH-1:0] load_data;
  logic             start;
  logic             stop;
  logic             periodic;
  logic             irq_ack;
  logic [WIDTH-1:0] count;
  logic             sel_load;
  logic             terminal;
  logic             running;
  logic             irq;

  modport master (
    output tick, load_wr, load_data, start, stop, periodic, irq_ack,
    input  count, sel_load, terminal, running, irq
  );

  modport slave (
    input  tick, load_wr, load_data, start, stop, periodic, irq_ack,
    output count, sel_load, terminal, running, irq
  );
endinterface

// File: rtl/slip_timer_seq.sv
// Loadable down-counter sequencer: reload register, start/stop FSM,
// terminal-count detection, load/count mux select and interrupt latch.
module slip_timer_seq #(
  parameter int WIDTH = 9
) (
  input logic               MasterClock,
  input logic               Reset,
  slip_timer_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] reload, cnt, cnt_next, reload_eff;
  logic             term_reg, irq_reg, term_event, sel_load, at_zero;

  // A reload write in the same cycle as a load goes straight into the counter.
  assign reload_eff = bus.load_wr ? bus.load_data : reload;
  assign at_zero    = (cnt == '0);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sel_load   = 1'b0;
    term_event = 1'b0;
    case (state)
      IDLE: if (bus.start && !bus.stop) state_next = ARM;
      ARM: begin
        if (bus.stop) begin
          state_next = IDLE;
        end else begin
          sel_load   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_next = IDLE;
        end else if (bus.start) begin
          state_next = ARM;
        end else if (bus.tick) begin
          if (at_zero) begin
            term_event = 1'b1;
            if (bus.periodic) sel_load   = 1'b1;
            else              state_next = DONE;
          end else begin
            cnt_next = cnt - WIDTH'(1);
          end
        end
      end
      DONE: begin
        if (bus.stop)       state_next = IDLE;
        else if (bus.start) state_next = ARM;
      end
      default: state_next = IDLE;
    endcase
    if (sel_load) cnt_next = reload_eff;
  end

  always_ff @(posedge MasterClock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      reload   <= '0;
      cnt      <= '0;
      term_reg <= 1'b0;
      irq_reg  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      term_reg <= term_event;
      // A fresh terminal event beats a simultaneous acknowledge.
      irq_reg  <= term_event | (irq_reg & ~bus.irq_ack);
      if (bus.load_wr) reload <= bus.load_data;
    end
  end

  assign bus.count    = cnt;
  assign bus.sel_load = sel_load;
  assign bus.terminal = term_reg;
  assign bus.running  = (state == ARM) || (state == RUN);
  assign bus.irq      = irq_reg;

endmodule
